// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one combinational 32-bit logic unit between NREQ requesters.
// Optional macro LOGIC_ARB_ZERO_FLAG_EN adds a registered rsp_zero flag alongside rsp_data.
module logic_op_arbiter #(
    parameter int unsigned NREQ  = 2,
    parameter int unsigned WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*WIDTH-1:0]   req_a,
    input  logic [NREQ*WIDTH-1:0]   req_b,
    input  logic [NREQ*2-1:0]       req_op,
    output logic [WIDTH-1:0]        lu_a,
    output logic [WIDTH-1:0]        lu_b,
    output logic [1:0]              lu_s,
    input  logic [WIDTH-1:0]        lu_y,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        rsp_data,
    output logic [1:0]              rsp_id
`ifdef LOGIC_ARB_ZERO_FLAG_EN
    ,
    output logic                    rsp_zero
`endif
);

    localparam int unsigned IDW = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [IDW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]     id_q, id_d;
    logic [WIDTH-1:0]   lu_a_q, lu_a_d;
    logic [WIDTH-1:0]   lu_b_q, lu_b_d;
    logic [1:0]         lu_s_q, lu_s_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic [IDW-1:0]     rsp_id_q, rsp_id_d;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
    logic               rsp_zero_q, rsp_zero_d;
`endif

    logic [3:0]         valid_ext;
    logic               grant_any_c;
    logic [IDW-1:0]     grant_id_c;
    int                 slot;

    // Round-robin search starting one past the last winner, wrapping at NREQ-1
    always_comb begin
        valid_ext   = 4'(req_valid);
        grant_any_c = 1'b0;
        grant_id_c  = '0;
        slot        = 0;
        for (int k = 1; k <= int'(NREQ); k++) begin
            slot = int'(rr_ptr_q) + k;
            if (slot >= int'(NREQ)) slot = slot - int'(NREQ);
            if (!grant_any_c && valid_ext[IDW'(slot)]) begin
                grant_any_c = 1'b1;
                grant_id_c  = IDW'(slot);
            end
        end
    end

    // Grant is only offered while idle
    always_comb begin
        req_ready = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            req_ready[i] = (state_q == IDLE) && grant_any_c && (grant_id_c == IDW'(i));
        end
    end

    // Next-state and datapath register updates
    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        lu_a_d      = lu_a_q;
        lu_b_d      = lu_b_q;
        lu_s_d      = lu_s_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
        rsp_zero_d  = rsp_zero_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_any_c) begin
                    id_d     = grant_id_c;
                    rr_ptr_d = grant_id_c;
                    lu_a_d   = req_a[int'(grant_id_c)*int'(WIDTH) +: WIDTH];
                    lu_b_d   = req_b[int'(grant_id_c)*int'(WIDTH) +: WIDTH];
                    lu_s_d   = req_op[int'(grant_id_c)*2 +: 2];
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                // Unit inputs return to zero once the result is captured
                rsp_data_d  = lu_y;
                rsp_id_d    = id_q;
                rsp_valid_d = 1'b1;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
                rsp_zero_d  = (lu_y == '0);
`endif
                lu_a_d      = '0;
                lu_b_d      = '0;
                lu_s_d      = '0;
                state_d     = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= IDW'(NREQ - 1);
            id_q        <= '0;
            lu_a_q      <= '0;
            lu_b_q      <= '0;
            lu_s_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
            rsp_zero_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            lu_a_q      <= lu_a_d;
            lu_b_q      <= lu_b_d;
            lu_s_q      <= lu_s_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
            rsp_zero_q  <= rsp_zero_d;
`endif
        end
    end

    assign lu_a      = lu_a_q;
    assign lu_b      = lu_b_q;
    assign lu_s      = lu_s_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
    assign rsp_zero  = rsp_zero_q;
`endif

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Directed bench for logic_op_arbiter (NREQ=2); models the shared logic unit on lu_*.
module tb_logic_op_arbiter;

    localparam int unsigned NREQ  = 2;
    localparam int unsigned WIDTH = 32;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a, req_b;
    logic [NREQ*2-1:0]     req_op;
    logic [WIDTH-1:0]      lu_a, lu_b, lu_y;
    logic [1:0]            lu_s;
    logic                  rsp_valid, rsp_ready;
    logic [WIDTH-1:0]      rsp_data;
    logic [1:0]            rsp_id;
`ifdef LOGIC_ARB_ZERO_FLAG_EN
    logic                  rsp_zero;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    logic_op_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_op    (req_op),
        .lu_a      (lu_a),
        .lu_b      (lu_b),
        .lu_s      (lu_s),
        .lu_y      (lu_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
`ifdef LOGIC_ARB_ZERO_FLAG_EN
        ,
        .rsp_zero  (rsp_zero)
`endif
    );

    always #5 clk = ~clk;

    // Shared logic unit model
    always_comb begin
        case (lu_s)
            2'b00:   lu_y = lu_a & lu_b;
            2'b01:   lu_y = lu_a | lu_b;
            2'b10:   lu_y = lu_a ^ lu_b;
            default: lu_y = ~(lu_a | lu_b);
        endcase
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        req_a[r*32 +: 32] = a;
        req_b[r*32 +: 32] = b;
        req_op[r*2 +: 2]  = op;
    endtask

    // Single-requester op with rsp_ready held high; checks the cycle-by-cycle timeline
    task automatic run_op(input string tag, input int r, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic [31:0] exp);
        set_req(r, a, b, op);
        rsp_ready = 1'b1;
        req_valid = 2'(1 << r);
        #1;
        chk({tag, ".ready"}, 64'(req_ready), 64'(1 << r));
        tick();
        req_valid = '0;
        chk({tag, ".exec_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, ".lu_a"}, 64'(lu_a), 64'(a));
        chk({tag, ".lu_b"}, 64'(lu_b), 64'(b));
        chk({tag, ".lu_s"}, 64'(lu_s), 64'(op));
        tick();
        chk({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd1);
        chk({tag, ".rsp_data"}, 64'(rsp_data), 64'(exp));
        chk({tag, ".rsp_id"}, 64'(rsp_id), 64'(r));
        chk({tag, ".lu_idle"}, 64'({lu_a, lu_s}), 64'd0);
`ifdef LOGIC_ARB_ZERO_FLAG_EN
        chk({tag, ".rsp_zero"}, 64'(rsp_zero), 64'(exp == 32'd0));
`endif
        tick();
        chk({tag, ".done"}, 64'(rsp_valid), 64'd0);
    endtask

    task automatic wait_rsp(input string tag);
        int cnt;
        cnt = 0;
        while (!rsp_valid && cnt < 8) begin
            tick();
            cnt++;
        end
        if (cnt >= 8) chk({tag, ".timeout"}, 64'(rsp_valid), 64'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_op    = '0;
        rsp_ready = 1'b0;
        #12;
        chk("rst.req_ready", 64'(req_ready), 64'd0);
        chk("rst.lu", 64'({lu_a, lu_b, lu_s}), 64'd0);
        chk("rst.rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst.rsp_data", 64'({rsp_data, rsp_id}), 64'd0);
        rst_n = 1'b1;
        tick();

        // Basic ops on requester 0
        run_op("and", 0, 32'hF0F0F0F0, 32'hFF00FF00, 2'b00, 32'hF000F000);
        run_op("or",  0, 32'hF0F0F0F0, 32'hFF00FF00, 2'b01, 32'hFFF0FFF0);
        run_op("xor", 0, 32'hF0F0F0F0, 32'hFF00FF00, 2'b10, 32'h0FF00FF0);
        run_op("nor", 0, 32'hF0F0F0F0, 32'hFF00FF00, 2'b11, 32'h000F000F);
        run_op("req1", 1, 32'h0000FFFF, 32'h00FF00FF, 2'b10, 32'h00FFFF00);

        // Both requesters continuously valid after reset: grants alternate 0,1,0,1
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        set_req(0, 32'h12345678, 32'h0000FFFF, 2'b00);
        set_req(1, 32'hAAAA5555, 32'hFFFF0000, 2'b10);
        rsp_ready = 1'b1;
        req_valid = 2'b11;
        for (int n = 0; n < 4; n++) begin
            wait_rsp("rr");
            chk($sformatf("rr%0d.id", n), 64'(rsp_id), 64'(n % 2));
            chk($sformatf("rr%0d.data", n), 64'(rsp_data), (n % 2 == 0) ? 64'h00005678 : 64'h55555555);
            tick();
        end
        req_valid = '0;
        tick();

        // Response back-pressure for 5 cycles
        rsp_ready = 1'b0;
        set_req(0, 32'hC3C3C3C3, 32'h0F0F0F0F, 2'b01);
        req_valid = 2'b01;
        wait_rsp("bp");
        req_valid = 2'b11;
        for (int n = 0; n < 5; n++) begin
            chk($sformatf("bp%0d.hold", n), {29'd0, rsp_valid, rsp_id, rsp_data}, {29'd0, 1'b1, 2'd0, 32'hCFCFCFCF});
            chk($sformatf("bp%0d.ready", n), 64'(req_ready), 64'd0);
            tick();
        end
        req_valid = '0;
        rsp_ready = 1'b1;
        tick();
        chk("bp.release", 64'(rsp_valid), 64'd0);

        // Reset during EXEC aborts the op; first grant afterwards goes to req0
        set_req(0, 32'hFFFFFFFF, 32'h0000FFFF, 2'b00);
        req_valid = 2'b01;
        tick();
        req_valid = '0;
        chk("abort.in_exec", 64'(lu_a), 64'hFFFFFFFF);
        rst_n = 1'b0;
        #1;
        chk("abort.lu", 64'({lu_a, lu_b, lu_s}), 64'd0);
        chk("abort.rsp", 64'({rsp_valid, rsp_id, rsp_data}), 64'd0);
        chk("abort.ready", 64'(req_ready), 64'd0);
        #2;
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            chk($sformatf("abort.quiet%0d", n), 64'(rsp_valid), 64'd0);
        end
        set_req(1, 32'h11111111, 32'h22222222, 2'b01);
        req_valid = 2'b11;
        #1;
        chk("abort.first_grant", 64'(req_ready), 64'd1);
        wait_rsp("abort");
        chk("abort.rsp_id", 64'(rsp_id), 64'd0);
        req_valid = '0;
        tick();
        tick();

        // Zero-result boundary
        run_op("zero", 0, 32'h0000FFFF, 32'hFFFF0000, 2'b00, 32'h00000000);
        run_op("ones", 0, 32'h0000FFFF, 32'hFFFF0000, 2'b01, 32'hFFFFFFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
